// File: rtl/exe_hazard_ctrl.sv
// Execute-stage sequencing control: operand forwarding selects, load-use stall,
// branch flush and memory-wait freeze, with a sticky memory-timeout flag.
module exe_hazard_ctrl #(
  parameter bit         FWD_EN      = 1'b1,
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic [3:0] id_dest,
  input  logic       id_wb_en,
  input  logic       id_mem_r_en,
  input  logic       id_mem_w_en,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic [1:0] sel_src_1,
  output logic [1:0] sel_src_2,
  output logic       stall,
  output logic       freeze,
  output logic       flush,
  output logic       mem_err
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  // A source matches a stage holding a valid register-writing instruction.
  function automatic logic stage_hit(input logic vld, input logic wb,
                                     input logic [3:0] dest, input logic [3:0] src);
    return vld & wb & (dest == src);
  endfunction

  logic       exe_valid_r, exe_two_src_r, exe_wb_r, exe_mem_r_r, exe_mem_w_r;
  logic [3:0] exe_src1_r, exe_src2_r, exe_dest_r;
  logic       mem_valid_r, mem_wb_r, mem_mem_r_r, mem_mem_w_r;
  logic [3:0] mem_dest_r;
  logic       wb_valid_r, wb_wb_r;
  logic [3:0] wb_dest_r;

  wait_state_t state_r, state_nxt_s;
  logic [7:0]  wcnt_r, wcnt_nxt_s;
  logic        mem_err_r, mem_err_nxt_s;

  logic       mem_busy_s, freeze_s, flush_s, stall_s, raw_stall_s, id_ins_s;
  logic       id_exe_hit_s, id_mem_hit_s;
  logic [1:0] sel_src_1_s, sel_src_2_s;

  assign mem_busy_s = mem_valid_r & (mem_mem_r_r | mem_mem_w_r);
  assign freeze_s   = mem_busy_s & ~mem_ready;
  // Reset gating keeps flush quiet while the pipeline view is being emptied.
  assign flush_s    = br_taken & ~freeze_s & rst;

  assign id_exe_hit_s = id_valid &
                        (stage_hit(exe_valid_r, exe_wb_r, exe_dest_r, id_src1) |
                         (id_two_src & stage_hit(exe_valid_r, exe_wb_r, exe_dest_r, id_src2)));
  assign id_mem_hit_s = id_valid &
                        (stage_hit(mem_valid_r, mem_wb_r, mem_dest_r, id_src1) |
                         (id_two_src & stage_hit(mem_valid_r, mem_wb_r, mem_dest_r, id_src2)));

  // RAW stall decision: load-use only with forwarding, any EXE/MEM producer without.
  always_comb begin
    raw_stall_s = 1'b0;
    if (FWD_EN == 1'b1) begin
      raw_stall_s = id_exe_hit_s & exe_mem_r_r;
    end else begin
      raw_stall_s = id_exe_hit_s | id_mem_hit_s;
    end
  end

  assign stall_s  = raw_stall_s & ~flush_s;
  assign id_ins_s = id_valid & ~stall_s & ~flush_s;

  // Operand forwarding selects for the instruction currently in EXE; MEM beats WB.
  always_comb begin
    sel_src_1_s = 2'b00;
    sel_src_2_s = 2'b00;
    if ((FWD_EN == 1'b1) && exe_valid_r) begin
      if (stage_hit(mem_valid_r, mem_wb_r, mem_dest_r, exe_src1_r)) begin
        sel_src_1_s = 2'b01;
      end else if (stage_hit(wb_valid_r, wb_wb_r, wb_dest_r, exe_src1_r)) begin
        sel_src_1_s = 2'b10;
      end else begin
        sel_src_1_s = 2'b00;
      end
      if (exe_two_src_r && stage_hit(mem_valid_r, mem_wb_r, mem_dest_r, exe_src2_r)) begin
        sel_src_2_s = 2'b01;
      end else if (exe_two_src_r && stage_hit(wb_valid_r, wb_wb_r, wb_dest_r, exe_src2_r)) begin
        sel_src_2_s = 2'b10;
      end else begin
        sel_src_2_s = 2'b00;
      end
    end else begin
      sel_src_1_s = 2'b00;
      sel_src_2_s = 2'b00;
    end
  end

  // Shadow pipeline advance; all stages hold while memory is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_valid_r   <= 1'b0;
      exe_src1_r    <= 4'd0;
      exe_src2_r    <= 4'd0;
      exe_two_src_r <= 1'b0;
      exe_dest_r    <= 4'd0;
      exe_wb_r      <= 1'b0;
      exe_mem_r_r   <= 1'b0;
      exe_mem_w_r   <= 1'b0;
      mem_valid_r   <= 1'b0;
      mem_dest_r    <= 4'd0;
      mem_wb_r      <= 1'b0;
      mem_mem_r_r   <= 1'b0;
      mem_mem_w_r   <= 1'b0;
      wb_valid_r    <= 1'b0;
      wb_dest_r     <= 4'd0;
      wb_wb_r       <= 1'b0;
    end else if (!freeze_s) begin
      wb_valid_r    <= mem_valid_r;
      wb_dest_r     <= mem_dest_r;
      wb_wb_r       <= mem_wb_r;
      mem_valid_r   <= exe_valid_r;
      mem_dest_r    <= exe_dest_r;
      mem_wb_r      <= exe_wb_r;
      mem_mem_r_r   <= exe_mem_r_r;
      mem_mem_w_r   <= exe_mem_w_r;
      exe_valid_r   <= id_ins_s;
      exe_src1_r    <= id_src1;
      exe_src2_r    <= id_src2;
      exe_two_src_r <= id_two_src;
      exe_dest_r    <= id_dest;
      exe_wb_r      <= id_ins_s & id_wb_en;
      exe_mem_r_r   <= id_ins_s & id_mem_r_en;
      exe_mem_w_r   <= id_ins_s & id_mem_w_en;
    end
  end

  // Wait FSM, wait counter and sticky timeout flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      wcnt_r    <= 8'd0;
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      wcnt_r    <= wcnt_nxt_s;
      mem_err_r <= mem_err_nxt_s;
    end
  end

  // Wait FSM next state; the counter saturates and never releases the freeze.
  always_comb begin
    state_nxt_s   = state_r;
    wcnt_nxt_s    = wcnt_r;
    mem_err_nxt_s = mem_err_r | (wcnt_r == MEM_TIMEOUT);
    case (state_r)
      ST_RUN: begin
        wcnt_nxt_s = 8'd0;
        if (freeze_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_nxt_s = ST_RUN;
          wcnt_nxt_s  = 8'd0;
        end else if (freeze_s && (wcnt_r != MEM_TIMEOUT)) begin
          state_nxt_s = ST_WAIT;
          wcnt_nxt_s  = wcnt_r + 8'd1;
        end else begin
          state_nxt_s = ST_WAIT;
          wcnt_nxt_s  = wcnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        wcnt_nxt_s  = 8'd0;
      end
    endcase
  end

  assign sel_src_1 = sel_src_1_s;
  assign sel_src_2 = sel_src_2_s;
  assign stall     = stall_s;
  assign freeze    = freeze_s;
  assign flush     = flush_s;
  assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: one forwarding and one non-forwarding instance driven
// in parallel and compared every cycle against an instruction-level pipeline model.
module tb_exe_hazard_ctrl;
  localparam int T = 4;

  logic       clk;
  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       br_taken, mem_ready;
  logic [1:0] sel1_o [2];
  logic [1:0] sel2_o [2];
  logic       stall_o [2];
  logic       freeze_o [2];
  logic       flush_o [2];
  logic       err_o [2];

  exe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(8'd4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .br_taken(br_taken),
    .mem_ready(mem_ready), .sel_src_1(sel1_o[0]), .sel_src_2(sel2_o[0]),
    .stall(stall_o[0]), .freeze(freeze_o[0]), .flush(flush_o[0]), .mem_err(err_o[0]));

  exe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(8'd4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .br_taken(br_taken),
    .mem_ready(mem_ready), .sel_src_1(sel1_o[1]), .sel_src_2(sel2_o[1]),
    .stall(stall_o[1]), .freeze(freeze_o[1]), .flush(flush_o[1]), .mem_err(err_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic [3:0] d;
    logic       wb;
    logic       mr;
    logic       mw;
  } ins_t;

  // Model: [config][0=EXE,1=MEM,2=WB]; config 0 forwards, config 1 does not.
  ins_t pipe [2][3];
  int   frz_run [2];
  logic err [2];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic hit(input ins_t p, input logic [3:0] s);
    return p.v && p.wb && (p.d == s);
  endfunction

  function automatic logic id_hit(input ins_t p);
    return id_valid && (hit(p, id_src1) || (id_two_src && hit(p, id_src2)));
  endfunction

  function automatic int model_sel(input int c, input logic [3:0] s, input logic used);
    if (c == 1 || !pipe[c][0].v || !used) return 0;
    if (hit(pipe[c][1], s)) return 1;
    if (hit(pipe[c][2], s)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) pipe[c][k] = '0;
      frz_run[c] = 0;
      err[c] = 1'b0;
    end
  endtask

  // Compare every output against the model, then advance the model across one edge.
  task automatic step();
    ins_t nx [2][3];
    logic nerr [2];
    int   nfrz [2];
    logic fz, fl, st;
    string tag;
    #2;
    for (int c = 0; c < 2; c++) begin
      tag = (c == 0) ? "fwd" : "nofwd";
      fz = pipe[c][1].v && (pipe[c][1].mr || pipe[c][1].mw) && !mem_ready;
      fl = br_taken && !fz;
      if (c == 0) st = id_hit(pipe[c][0]) && pipe[c][0].mr;
      else        st = id_hit(pipe[c][0]) || id_hit(pipe[c][1]);
      st = st && !fl;
      check({tag, ".sel1"},   int'(sel1_o[c]),   model_sel(c, pipe[c][0].s1, 1'b1));
      check({tag, ".sel2"},   int'(sel2_o[c]),   model_sel(c, pipe[c][0].s2, pipe[c][0].two));
      check({tag, ".stall"},  int'(stall_o[c]),  int'(st));
      check({tag, ".freeze"}, int'(freeze_o[c]), int'(fz));
      check({tag, ".flush"},  int'(flush_o[c]),  int'(fl));
      check({tag, ".mem_err"}, int'(err_o[c]),   int'(err[c]));
      nerr[c] = err[c] || (frz_run[c] >= T + 1);
      nfrz[c] = fz ? frz_run[c] + 1 : 0;
      for (int k = 0; k < 3; k++) nx[c][k] = pipe[c][k];
      if (!fz) begin
        nx[c][2]     = pipe[c][1];
        nx[c][1]     = pipe[c][0];
        nx[c][0].v   = id_valid && !st && !fl;
        nx[c][0].s1  = id_src1;
        nx[c][0].s2  = id_src2;
        nx[c][0].two = id_two_src;
        nx[c][0].d   = id_dest;
        nx[c][0].wb  = nx[c][0].v && id_wb_en;
        nx[c][0].mr  = nx[c][0].v && id_mem_r_en;
        nx[c][0].mw  = nx[c][0].v && id_mem_w_en;
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) pipe[c][k] = nx[c][k];
      err[c] = nerr[c];
      frz_run[c] = nfrz[c];
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb,
                        input logic mr, input logic mw);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_r_en = mr; id_mem_w_en = mw;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string name);
    for (int c = 0; c < 2; c++) begin
      check({name, ".sel1"},    int'(sel1_o[c]),   0);
      check({name, ".sel2"},    int'(sel2_o[c]),   0);
      check({name, ".stall"},   int'(stall_o[c]),  0);
      check({name, ".freeze"},  int'(freeze_o[c]), 0);
      check({name, ".flush"},   int'(flush_o[c]),  0);
      check({name, ".mem_err"}, int'(err_o[c]),    0);
    end
  endtask

  int hold;

  initial begin
    rst = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
    set_id(1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // Forwarding from MEM, then WB, then MEM priority over WB.
    set_id(1'b1, 4'd5, 4'd6, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 4'd1, 4'd8, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0); #1;
    check("d.alu_nostall", int'(stall_o[0]), 0);
    check("d.nofwd_stall", int'(stall_o[1]), 1);
    step();
    set_id(1'b1, 4'd10, 4'd1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0); #1;
    check("d.fwd_mem", int'(sel1_o[0]), 1);
    step();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0); #1;
    check("d.fwd_wb_src2", int'(sel2_o[0]), 2);
    check("d.src1_none",   int'(sel1_o[0]), 0);
    step();
    step();
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 4'd11, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0); #1;
    check("d.mem_over_wb", int'(sel1_o[0]), 1);
    step();

    // Load-use: one stall, bubble, then forward from WB.
    set_id(1'b1, 4'd2, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0); #1;
    check("d.loaduse_stall", int'(stall_o[0]), 1);
    step();
    #1;
    check("d.loaduse_once", int'(stall_o[0]), 0);
    step();
    set_id(1'b1, 4'd11, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0); #1;
    check("d.loaduse_fwd_wb", int'(sel1_o[0]), 2);
    step();
    set_id(1'b1, 4'd13, 4'd2, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0); #1;
    check("d.unused_src2", int'(stall_o[0]), 0);
    step();
    idle(3);

    // No forwarding: two-cycle stall, selects stay 00.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b1, 4'd4, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0); #1;
    check("d.nf_stall1", int'(stall_o[1]), 1);
    check("d.nf_fwd_alu", int'(stall_o[0]), 0);
    step();
    #1;
    check("d.nf_stall2", int'(stall_o[1]), 1);
    check("d.nf_sel", int'(sel1_o[1]), 0);
    step();
    #1;
    check("d.nf_release", int'(stall_o[1]), 0);
    step();
    idle(3);

    // Branch wins over a load-use stall; the ID instruction is discarded.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0); step();
    set_id(1'b1, 4'd2, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0); br_taken = 1'b1; #1;
    check("d.br_flush", int'(flush_o[0]), 1);
    check("d.br_nostall", int'(stall_o[0]), 0);
    check("d.br_nostall_nf", int'(stall_o[1]), 0);
    step();
    br_taken = 1'b0;
    set_id(1'b1, 4'd12, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0); #1;
    check("d.br_bubble", int'(stall_o[1]), 0);
    step();
    idle(3);

    // Store waiting three cycles; branch ignored while frozen.
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1); step();
    set_id(1'b1, 4'd1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0); step();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      br_taken = (i == 1);
      #1;
      check("d.freeze", int'(freeze_o[0]), 1);
      if (i == 1) check("d.br_in_freeze", int'(flush_o[0]), 0);
      step();
    end
    br_taken = 1'b0; mem_ready = 1'b1; #1;
    check("d.freeze_release", int'(freeze_o[0]), 0);
    step();
    idle(3);

    // Timeout: five wait cycles with limit 4 sets the sticky flag.
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1); step();
    idle(1);
    mem_ready = 1'b0;
    idle(5);
    mem_ready = 1'b1; #1;
    check("d.err_not_yet", int'(err_o[0]), 0);
    step();
    #1;
    check("d.err_set", int'(err_o[0]), 1);
    check("d.err_set_nf", int'(err_o[1]), 1);
    idle(3);
    #1;
    check("d.err_sticky", int'(err_o[0]), 1);

    // Asynchronous reset in the middle of a wait with the flag set.
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1); step();
    idle(1);
    mem_ready = 1'b0;
    idle(3);
    br_taken = 1'b1;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk); #3;
    rst = 1'b1; br_taken = 1'b0; mem_ready = 1'b1;
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic over a small register set to provoke hazards.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      set_id($urandom_range(0, 99) < 85, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             kind <= 1, kind == 1, kind == 2);
      br_taken = ($urandom_range(0, 99) < 10);
      if (hold > 0) begin
        mem_ready = 1'b0;
        hold--;
      end else begin
        mem_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 99) < 2) hold = 6;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
